// File: rtl/codebook_decompressor.sv
// codebook_decompressor: NCODES-lane codebook lookup behind one valid/ready register stage.
// Define DECOMP_MISS_CNT_EN to build the saturating miss counter; otherwise miss_count reads 0.
module codebook_decompressor #(
    parameter int  SYM_W  = 6,
    parameter int  CODE_W = 2,
    parameter int  NENT   = 4,
    parameter int  NCODES = 4,
    localparam int IDX_W  = (NENT > 1) ? $clog2(NENT) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cb_we,
    input  logic [IDX_W-1:0]         cb_idx,
    input  logic [CODE_W-1:0]        cb_code,
    input  logic [SYM_W-1:0]         cb_sym,
    input  logic                     cb_clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NCODES*CODE_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NCODES*SYM_W-1:0]  out_data,
    output logic [NCODES-1:0]        out_miss,
    output logic [15:0]              miss_count
);

    logic [NENT-1:0]   cb_vld_q;
    logic [CODE_W-1:0] cb_code_q [NENT];
    logic [SYM_W-1:0]  cb_sym_q  [NENT];

    logic [NCODES*SYM_W-1:0] lk_data;
    logic [NCODES-1:0]       lk_miss;
    logic                    accept;

    logic                    out_valid_q;
    logic [NCODES*SYM_W-1:0] out_data_q;
    logic [NCODES-1:0]       out_miss_q;

    // Indices at or above NENT match no entry, so such writes fall through harmlessly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cb_vld_q <= '0;
            for (int unsigned e = 0; e < NENT; e++) begin
                cb_code_q[e] <= '0;
                cb_sym_q[e]  <= '0;
            end
        end else if (cb_clear) begin
            cb_vld_q <= '0;
            for (int unsigned e = 0; e < NENT; e++) begin
                cb_code_q[e] <= '0;
                cb_sym_q[e]  <= '0;
            end
        end else if (cb_we) begin
            for (int unsigned e = 0; e < NENT; e++) begin
                if (cb_idx == IDX_W'(e)) begin
                    cb_vld_q[e]  <= 1'b1;
                    cb_code_q[e] <= cb_code;
                    cb_sym_q[e]  <= cb_sym;
                end
            end
        end
    end

    // Scan entries from high to low so the lowest matching index is the one left standing.
    always_comb begin
        lk_data = '0;
        lk_miss = '1;
        for (int unsigned l = 0; l < NCODES; l++) begin
            for (int unsigned e = NENT; e > 0; e--) begin
                if (cb_vld_q[e-1] && (cb_code_q[e-1] == in_data[l*CODE_W +: CODE_W])) begin
                    lk_data[l*SYM_W +: SYM_W] = cb_sym_q[e-1];
                    lk_miss[l]                = 1'b0;
                end
            end
        end
    end

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_miss_q  <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= lk_data;
            out_miss_q  <= lk_miss;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_miss  = out_miss_q;

`ifdef DECOMP_MISS_CNT_EN
    logic [15:0] miss_cnt_q;
    logic [15:0] miss_cnt_d;
    logic [16:0] miss_sum;

    always_comb begin
        miss_sum = {1'b0, miss_cnt_q};
        for (int unsigned l = 0; l < NCODES; l++) begin
            miss_sum = miss_sum + 17'(lk_miss[l]);
        end
        miss_cnt_d = miss_sum[16] ? '1 : miss_sum[15:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miss_cnt_q <= '0;
        end else if (accept) begin
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign miss_count = miss_cnt_q;
`else
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_codebook_decompressor.sv
// Self-checking bench for codebook_decompressor: directed table, hand sequences, random traffic
// against a cycle-level reference model of the codebook and output register.
module tb_codebook_decompressor;

    localparam int SYM_W  = 6;
    localparam int CODE_W = 2;
    localparam int NENT   = 4;
    localparam int NCODES = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cb_we;
    logic [1:0]  cb_idx;
    logic [1:0]  cb_code;
    logic [5:0]  cb_sym;
    logic        cb_clear;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic [3:0]  out_miss;
    logic [15:0] miss_count;

    codebook_decompressor #(
        .SYM_W (SYM_W),
        .CODE_W(CODE_W),
        .NENT  (NENT),
        .NCODES(NCODES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cb_we     (cb_we),
        .cb_idx    (cb_idx),
        .cb_code   (cb_code),
        .cb_sym    (cb_sym),
        .cb_clear  (cb_clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_miss  (out_miss),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic        m_vld  [NENT];
    logic [1:0]  m_code [NENT];
    logic [5:0]  m_sym  [NENT];
    logic        m_ov;
    logic [23:0] m_data;
    logic [3:0]  m_miss;
    int          m_cnt;

    typedef struct {
        logic [7:0]  din;
        logic [23:0] dout;
        logic [3:0]  miss;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_cnt();
`ifdef DECOMP_MISS_CNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    function automatic void m_reset();
        for (int e = 0; e < NENT; e++) begin
            m_vld[e] = 1'b0; m_code[e] = '0; m_sym[e] = '0;
        end
        m_ov = 1'b0; m_data = '0; m_miss = '0; m_cnt = 0;
    endfunction

    function automatic void ref_decode(input logic [7:0] w, output logic [23:0] d,
                                       output logic [3:0] ms);
        logic [1:0] c;
        int         hit;
        d  = '0;
        ms = '0;
        for (int l = 0; l < NCODES; l++) begin
            c   = w[l*2 +: 2];
            hit = -1;
            for (int e = 0; e < NENT; e++) begin
                if (hit < 0 && m_vld[e] && m_code[e] == c) hit = e;
            end
            if (hit < 0) ms[l] = 1'b1;
            else         d[l*6 +: 6] = m_sym[hit];
        end
    endfunction

    // Entered #1 after a rising edge with new inputs already driven; returns #1 after the next edge.
    task automatic tick();
        logic        acc;
        logic [23:0] d;
        logic [3:0]  ms;
        #1;
        chk("in_ready", 32'(in_ready), 32'(!m_ov || out_ready));
        acc = in_valid && (!m_ov || out_ready);
        if (acc) begin
            ref_decode(in_data, d, ms);
            m_data = d;
            m_miss = ms;
            m_ov   = 1'b1;
            m_cnt  = m_cnt + $countones(ms);
            if (m_cnt > 65535) m_cnt = 65535;
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        if (cb_clear) begin
            for (int e = 0; e < NENT; e++) begin
                m_vld[e] = 1'b0; m_code[e] = '0; m_sym[e] = '0;
            end
        end else if (cb_we) begin
            m_vld[cb_idx] = 1'b1; m_code[cb_idx] = cb_code; m_sym[cb_idx] = cb_sym;
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_miss", 32'(out_miss), 32'(m_miss));
        chk("miss_count", 32'(miss_count), 32'(exp_cnt()));
    endtask

    task automatic cb_write(input logic [1:0] idx, input logic [1:0] code, input logic [5:0] sym);
        cb_we = 1'b1; cb_idx = idx; cb_code = code; cb_sym = sym;
        in_valid = 1'b0;
        tick();
        cb_we = 1'b0;
    endtask

    task automatic cb_clr();
        cb_clear = 1'b1; in_valid = 1'b0;
        tick();
        cb_clear = 1'b0;
    endtask

    task automatic load_basic();
        cb_clr();
        cb_write(2'd0, 2'b00, 6'h11);
        cb_write(2'd1, 2'b01, 6'h22);
        cb_write(2'd2, 2'b10, 6'h33);
        cb_write(2'd3, 2'b11, 6'h3F);
    endtask

    task automatic apply_vec(input int i);
        in_valid = 1'b1; in_data = vecs[i].din; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].dout));
        chk($sformatf("vec%0d_miss", i), 32'(out_miss), 32'(vecs[i].miss));
    endtask

    initial begin
        vecs[0] = '{8'b11_10_01_00, 24'hFF3891, 4'h0};
        vecs[1] = '{8'h00,          24'h451451, 4'h0};
        vecs[2] = '{8'hFF,          24'hFFFFFF, 4'h0};
        vecs[3] = '{8'h1B,          24'h462CFF, 4'h0};
        vecs[4] = '{8'h55,          24'h28A28A, 4'h0};
        vecs[5] = '{8'h00,          24'h000000, 4'hF};
        vecs[6] = '{8'h05,          24'h00028A, 4'hC};

        reset = 1'b1; cb_we = 1'b0; cb_idx = '0; cb_code = '0; cb_sym = '0; cb_clear = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        m_reset();
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_miss", 32'(out_miss), 32'd0);
        chk("rst_miss_count", 32'(miss_count), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Empty codebook
        in_valid = 1'b1; in_data = 8'h1B; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("empty_data", 32'(out_data), 32'd0);
        chk("empty_miss", 32'(out_miss), 32'hF);
`ifdef DECOMP_MISS_CNT_EN
        chk("empty_cnt", 32'(miss_count), 32'd4);
`else
        chk("empty_cnt", 32'(miss_count), 32'd0);
`endif

        load_basic();
        for (int i = 0; i < 4; i++) apply_vec(i);

        // Duplicate priority: entries 0 and 2 both carry code 01
        cb_clr();
        cb_write(2'd0, 2'b01, 6'h0A);
        cb_write(2'd2, 2'b01, 6'h15);
        for (int i = 4; i < 7; i++) apply_vec(i);

        // Backpressure: A held, B waits, then both delivered in order
        load_basic();
        in_valid = 1'b1; in_data = 8'h00; out_ready = 1'b0;
        tick();
        in_data = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_data", 32'(out_data), 32'h451451);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp_b_data", 32'(out_data), 32'hFFFFFF);
        chk("bp_b_valid", 32'(out_valid), 32'd1);
        tick();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Write/accept collision uses the pre-write codebook
        cb_we = 1'b1; cb_idx = 2'd1; cb_code = 2'b01; cb_sym = 6'h07;
        in_valid = 1'b1; in_data = 8'h01; out_ready = 1'b1;
        tick();
        cb_we = 1'b0;
        chk("coll_first", 32'(out_data[5:0]), 32'h22);
        tick();
        in_valid = 1'b0;
        chk("coll_second", 32'(out_data[5:0]), 32'h07);
        cb_clear = 1'b1; cb_we = 1'b1; cb_idx = 2'd0; cb_code = 2'b00; cb_sym = 6'h03;
        tick();
        cb_clear = 1'b0; cb_we = 1'b0;
        in_valid = 1'b1; in_data = 8'h00;
        tick();
        in_valid = 1'b0;
        chk("clr_wins_miss", 32'(out_miss), 32'hF);

        // Reset mid-stream while stalled
        load_basic();
        in_valid = 1'b1; in_data = 8'h1B; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        m_reset();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_miss", 32'(out_miss), 32'd0);
        chk("mid_rst_cnt", 32'(miss_count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_valid = 1'b1; in_data = 8'h1B; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post_rst_miss", 32'(out_miss), 32'hF);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            cb_we     = 1'($urandom_range(0, 5) == 0);
            cb_clear  = 1'($urandom_range(0, 40) == 0);
            cb_idx    = 2'($urandom);
            cb_code   = 2'($urandom);
            cb_sym    = 6'($urandom);
            tick();
        end
        cb_we = 1'b0; cb_clear = 1'b0; in_valid = 1'b0;

        // Saturation: full-rate all-miss words push the counter past 16'hFFFF
        cb_clr();
        in_valid = 1'b1; in_data = 8'h00; out_ready = 1'b1;
        for (int k = 0; k < 16400; k++) tick();
        in_valid = 1'b0;
`ifdef DECOMP_MISS_CNT_EN
        chk("sat_cnt", 32'(miss_count), 32'hFFFF);
`else
        chk("sat_cnt", 32'(miss_count), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
